// File: rtl/ycbcr_pkg.sv
// Shared BT.601 full-range Q2.14 constants and types for the RGB<->YCbCr converters.
package ycbcr_pkg;

    localparam int unsigned Q_SHIFT = 14;
    localparam int          ROUND_K = 8192;

    localparam int K_YR  = 4899;
    localparam int K_YG  = 9617;
    localparam int K_YB  = 1868;
    localparam int K_CBR = -2765;
    localparam int K_CBG = -5427;
    localparam int K_CBB = 8192;
    localparam int K_CRR = 8192;
    localparam int K_CRG = -6860;
    localparam int K_CRB = -1332;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    typedef struct packed {
        logic sof;
        logic eol;
    } side_t;

    // Mid-scale chroma offset pre-shifted into Q2.14.
    function automatic logic signed [31:0] chroma_offset(input int unsigned bw);
        return 32'sd1 <<< (bw - 1 + Q_SHIFT);
    endfunction

endpackage

// File: rtl/q14_round_clamp.sv
// Rounds a signed Q2.14 accumulator to an integer pixel and clamps it to 0..2^BW-1.
module q14_round_clamp
    import ycbcr_pkg::*;
#(
    parameter int unsigned BW = 8
) (
    input  logic signed [31:0]   sum,
    output logic        [BW-1:0] value_c
);

    localparam int MAXV = (1 << BW) - 1;

    logic signed [31:0] rnd;

    always_comb begin
        rnd = (sum + ROUND_K) >>> Q_SHIFT;
        if (rnd < 0) begin
            value_c = '0;
        end else if (rnd > MAXV) begin
            value_c = BW'(MAXV);
        end else begin
            value_c = BW'(rnd);
        end
    end

endmodule

// File: rtl/rgb_to_ycbcr422.sv
// RGB to co-sited YCbCr 4:2:2 converter: MAC, round/clamp, then chroma-phase pack.
module rgb_to_ycbcr422
    import ycbcr_pkg::*;
#(
    parameter int unsigned BW    = 8,
    parameter int unsigned COEFW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid_in,
    output logic          ready_in,
    input  logic          sof_in,
    input  logic          eol_in,
    input  logic [BW-1:0] R_in,
    input  logic [BW-1:0] G_in,
    input  logic [BW-1:0] B_in,
    output logic          valid_out,
    input  logic          ready_out,
    output logic          sof_out,
    output logic          eol_out,
    output logic [BW-1:0] Y_out,
    output logic [BW-1:0] C_out,
    output logic          c_is_cr
);

    localparam logic signed [31:0] C_OFS = chroma_offset(BW);

    // Coefficient quantised to COEFW bits, then sign-extended for a 32-bit product.
    function automatic logic signed [31:0] mac(input int k, input logic [BW-1:0] x);
        logic signed [COEFW-1:0] kq;
        kq = COEFW'(k);
        return 32'(kq) * $signed(32'(x));
    endfunction

    logic en;
    assign en       = !valid_out || ready_out;
    assign ready_in = en;

    // S1: multiply-accumulate
    logic               s1_valid;
    side_t              s1_side;
    logic signed [31:0] s1_y;
    logic signed [31:0] s1_cb;
    logic signed [31:0] s1_cr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_side  <= '0;
            s1_y     <= '0;
            s1_cb    <= '0;
            s1_cr    <= '0;
        end else if (en) begin
            s1_valid <= valid_in;
            s1_side  <= '{sof: sof_in & valid_in, eol: eol_in & valid_in};
            if (valid_in) begin
                s1_y  <= mac(K_YR, R_in) + mac(K_YG, G_in) + mac(K_YB, B_in);
                s1_cb <= mac(K_CBR, R_in) + mac(K_CBG, G_in) + mac(K_CBB, B_in) + C_OFS;
                s1_cr <= mac(K_CRR, R_in) + mac(K_CRG, G_in) + mac(K_CRB, B_in) + C_OFS;
            end
        end
    end

    // S2: round and clamp
    logic [BW-1:0] y_c;
    logic [BW-1:0] cb_c;
    logic [BW-1:0] cr_c;

    q14_round_clamp #(.BW(BW)) u_rc_y  (.sum(s1_y),  .value_c(y_c));
    q14_round_clamp #(.BW(BW)) u_rc_cb (.sum(s1_cb), .value_c(cb_c));
    q14_round_clamp #(.BW(BW)) u_rc_cr (.sum(s1_cr), .value_c(cr_c));

    logic          s2_valid;
    side_t         s2_side;
    logic [BW-1:0] s2_y;
    logic [BW-1:0] s2_cb;
    logic [BW-1:0] s2_cr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_side  <= '0;
            s2_y     <= '0;
            s2_cb    <= '0;
            s2_cr    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_side  <= s1_side;
            if (s1_valid) begin
                s2_y  <= y_c;
                s2_cb <= cb_c;
                s2_cr <= cr_c;
            end
        end
    end

    // S3: chroma phase FSM; sof forces the even phase
    phase_e        phase_q;
    phase_e        phase_d;
    logic [BW-1:0] cr_hold;
    logic [BW-1:0] c_sel_c;
    logic          cis_c;
    logic          hold_ld_c;
    logic          adv_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= PH_EVEN;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        c_sel_c   = s2_cb;
        cis_c     = 1'b0;
        hold_ld_c = 1'b0;
        adv_c     = en && s2_valid;
        if (s2_side.sof || phase_q == PH_EVEN) begin
            hold_ld_c = adv_c;
            if (adv_c) begin
                phase_d = s2_side.eol ? PH_EVEN : PH_ODD;
            end
        end else begin
            c_sel_c = cr_hold;
            cis_c   = 1'b1;
            if (adv_c) begin
                phase_d = PH_EVEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            eol_out   <= 1'b0;
            Y_out     <= '0;
            C_out     <= '0;
            c_is_cr   <= 1'b0;
            cr_hold   <= '0;
        end else if (en) begin
            valid_out <= s2_valid;
            if (s2_valid) begin
                sof_out <= s2_side.sof;
                eol_out <= s2_side.eol;
                Y_out   <= s2_y;
                C_out   <= c_sel_c;
                c_is_cr <= cis_c;
            end
            if (hold_ld_c) begin
                cr_hold <= s2_cr;
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_ycbcr422.sv
// Scoreboard bench for rgb_to_ycbcr422 with hand-computed BT.601 colour vectors.
module tb_rgb_to_ycbcr422;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic       sof_in = 1'b0;
    logic       eol_in = 1'b0;
    logic [7:0] r_drv = '0;
    logic [7:0] g_drv = '0;
    logic [7:0] b_drv = '0;
    logic       valid_out;
    logic       ready_out = 1'b1;
    logic       sof_out;
    logic       eol_out;
    logic [7:0] Y_out;
    logic [7:0] C_out;
    logic       c_is_cr;

    rgb_to_ycbcr422 #(.BW(8), .COEFW(16)) dut (
        .clk(clk), .rstn(rstn),
        .valid_in(valid_in), .ready_in(ready_in),
        .sof_in(sof_in), .eol_in(eol_in),
        .R_in(r_drv), .G_in(g_drv), .B_in(b_drv),
        .valid_out(valid_out), .ready_out(ready_out),
        .sof_out(sof_out), .eol_out(eol_out),
        .Y_out(Y_out), .C_out(C_out), .c_is_cr(c_is_cr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic [7:0] c;
        logic       cis;
        logic       sof;
        logic       eol;
        int         drv;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // white, red, black, green, blue, gray: inputs and hand-computed Y/Cb/Cr
    logic [7:0] tr [6] = '{255, 255,   0,   0,   0, 128};
    logic [7:0] tg [6] = '{255,   0,   0, 255,   0, 128};
    logic [7:0] tbl[6] = '{255,   0,   0,   0, 255, 128};
    logic [7:0] ty [6] = '{255,  76,   0, 150,  29, 128};
    logic [7:0] tcb[6] = '{128,  85, 128,  44, 255, 128};
    logic [7:0] tcr[6] = '{128, 255, 128,  21, 107, 128};

    bit         ph_odd = 1'b0;
    logic [7:0] hold_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks hold stability under stall, pops on each transfer
    exp_t        mon_e;
    logic [18:0] snap;
    bit          stalled = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if ({Y_out, C_out, c_is_cr, sof_out, eol_out} !== snap) begin
                    failures++;
                    $display("FAIL hold_stable: got %h required %h",
                             {Y_out, C_out, c_is_cr, sof_out, eol_out}, snap);
                end
            end
            stalled = valid_out && !ready_out;
            snap    = {Y_out, C_out, c_is_cr, sof_out, eol_out};
            if (valid_out && ready_out) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_sample: got Y=%0d C=%0d cis=%0d required none",
                             Y_out, C_out, c_is_cr);
                end else begin
                    mon_e = sb.pop_front();
                    if ({Y_out, C_out, c_is_cr, sof_out, eol_out} !==
                        {mon_e.y, mon_e.c, mon_e.cis, mon_e.sof, mon_e.eol}) begin
                        failures++;
                        $display("FAIL sample: got Y=%0d C=%0d cis=%0d sof=%0d eol=%0d required Y=%0d C=%0d cis=%0d sof=%0d eol=%0d",
                                 Y_out, C_out, c_is_cr, sof_out, eol_out,
                                 mon_e.y, mon_e.c, mon_e.cis, mon_e.sof, mon_e.eol);
                    end
                    if (mon_e.lat) begin
                        checks++;
                        if (cyc - mon_e.drv != 3) begin
                            failures++;
                            $display("FAIL latency: got %0d required 3", cyc - mon_e.drv);
                        end
                    end
                end
            end
        end
    end

    // Drive one pixel until accepted; pushes the 4:2:2 expectation first
    task automatic send(input int idx, input bit sof, input bit eol, input bit lat);
        exp_t e;
        int   n;
        e.y   = ty[idx];
        e.sof = sof;
        e.eol = eol;
        e.drv = cyc;
        e.lat = lat;
        if (sof || !ph_odd) begin
            e.c    = tcb[idx];
            e.cis  = 1'b0;
            hold_m = tcr[idx];
            ph_odd = !eol;
        end else begin
            e.c    = hold_m;
            e.cis  = 1'b1;
            ph_odd = 1'b0;
        end
        sb.push_back(e);
        valid_in = 1'b1;
        sof_in   = sof;
        eol_in   = eol;
        r_drv    = tr[idx];
        g_drv    = tg[idx];
        b_drv    = tbl[idx];
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_in) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: got ready_in=0 required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        eol_in   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string name);
        checks++;
        if ({valid_out, sof_out, eol_out, Y_out, C_out, c_is_cr, ready_in} !== 23'h1) begin
            failures++;
            $display("FAIL %s: got vo=%0d so=%0d eo=%0d Y=%0d C=%0d cis=%0d ri=%0d required all 0 and ri=1",
                     name, valid_out, sof_out, eol_out, Y_out, C_out, c_is_cr, ready_in);
        end
    endtask

    initial begin
        #3;
        chk_reset("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        checks++;
        if (ready_in !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %0d required 1", ready_in);
        end

        // white pair with latency check
        send(0, 1'b1, 1'b0, 1'b1);
        send(0, 1'b0, 1'b1, 1'b1);
        drain();

        // clamp: red then black, Cr of red saturates at 255
        send(1, 1'b1, 1'b0, 1'b0);
        send(2, 1'b0, 1'b1, 1'b0);
        drain();

        // backpressure: 8-pixel line, ready_out low for 4 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(i % 6, i == 0, i == 7, 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                ready_out = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checks++;
                    if (ready_in !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_ready_in: got %0d required 0", ready_in);
                    end
                end
                @(posedge clk);
                #1;
                ready_out = 1'b1;
            end
        join
        drain();

        // odd-length line then a new line
        send(3, 1'b1, 1'b0, 1'b0);
        send(4, 1'b0, 1'b0, 1'b0);
        send(5, 1'b0, 1'b1, 1'b0);
        send(2, 1'b0, 1'b0, 1'b0);
        send(1, 1'b0, 1'b1, 1'b0);
        drain();

        // sof arriving on an odd-phase pixel restarts the pairing
        send(0, 1'b1, 1'b0, 1'b0);
        send(3, 1'b1, 1'b1, 1'b0);
        send(4, 1'b0, 1'b0, 1'b0);
        send(5, 1'b0, 1'b1, 1'b0);
        drain();

        // reset while pixels are in flight; they must be dropped
        send(1, 1'b1, 1'b0, 1'b0);
        send(3, 1'b0, 1'b0, 1'b0);
        send(5, 1'b0, 1'b1, 1'b0);
        rstn = 1'b0;
        sb.delete();
        ph_odd = 1'b0;
        #1;
        chk_reset("reset_midstream");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        checks++;
        if (ready_in !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_midreset: got %0d required 1", ready_in);
        end
        send(4, 1'b1, 1'b0, 1'b1);
        send(5, 1'b0, 1'b1, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_to_ycbcr422.md
RGB_TO_YCBCR422 -- requirements
Module: rgb_to_ycbcr422

Interface
REQ-001 SHALL have parameter BW, default 8: bits per component, in and out.
REQ-002 SHALL have parameter COEFW, default 16: signed Q2.14 coefficient width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_in, input, 1: input pixel valid.
REQ-006 SHALL have port ready_in, output, 1: block accepts a pixel this cycle.
REQ-007 SHALL have port sof_in, input, 1: first pixel of frame; sideband qualified by valid_in.
REQ-008 SHALL have port eol_in, input, 1: last pixel of line; sideband qualified by valid_in.
REQ-009 SHALL have ports R_in, G_in, B_in, input, BW each: unsigned full-range RGB.
REQ-010 SHALL have port valid_out, output, 1: output sample valid.
REQ-011 SHALL have port ready_out, input, 1: downstream accepts the sample.
REQ-012 SHALL have ports sof_out and eol_out, output, 1 each: sof_in/eol_in delayed with their pixel.
REQ-013 SHALL have port Y_out, output, BW: luma.
REQ-014 SHALL have port C_out, output, BW: chroma sample, Cb or Cr.
REQ-015 SHALL have port c_is_cr, output, 1: 0 = C_out is Cb, 1 = C_out is Cr.

Function
REQ-016 SHALL compute full-range BT.601 (JFIF) Q2.14: Y = 4899R + 9617G + 1868B; Cb = -2765R - 5427G + 8192B + (2^(BW-1) << 14); Cr = 8192R - 6860G - 1332B + (2^(BW-1) << 14).
REQ-017 SHALL hold products and sums in 32-bit signed accumulators; no intermediate truncation.
REQ-018 SHALL convert each sum as (sum + 8192) >>> 14, then clamp to 0..2^BW-1.
REQ-019 SHALL be a 3-stage pipeline: S1 multiply-accumulate, S2 round/clamp, S3 4:2:2 pack into output registers.
REQ-020 SHALL give a 3-cycle latency without stall: a pixel accepted at edge N is presented with valid_out=1 after edge N+3.
REQ-021 SHALL use one global advance enable, en = !valid_out || ready_out; ready_in = en; all stages hold when en=0.
REQ-022 SHALL keep outputs and sideband stable while valid_out=1 and ready_out=0; no sample lost or duplicated.
REQ-023 SHALL implement chroma phase FSM states EVEN and ODD for co-sited 4:2:2.
REQ-024 SHALL, in EVEN: emit {Y, Cb} of the pixel with c_is_cr=0, store its Cr in cr_hold, go to ODD; if eol, stay in EVEN.
REQ-025 SHALL, in ODD: emit {Y, cr_hold} with c_is_cr=1, go to EVEN.
REQ-026 SHALL treat a pixel with sof=1 as EVEN regardless of current state; sof mid-line discards any pending cr_hold.
REQ-027 SHALL emit an odd-length line's last pixel as Cb-only; the next line starts in EVEN.
REQ-028 SHALL advance the FSM only when an S3 transfer occurs (en=1 and S2 valid).

Reset
REQ-029 SHALL, with rstn low, asynchronously clear valid_out, sof_out, eol_out, Y_out, C_out, c_is_cr, cr_hold, all stage valids and data to 0, and set FSM to EVEN.
REQ-030 SHALL drop in-flight pixels on reset mid-stream; the first post-reset output is the first pixel accepted after rstn rises.
REQ-031 SHALL drive ready_in = 1 during and immediately after reset (valid_out=0).

Structure
REQ-032 SHALL define coefficients, Q2.14 shift (14), rounding constant (8192) and chroma offset in shared package ycbcr_pkg, shared with the decode-side converter.
REQ-033 SHALL place round/clamp in one sub-module q14_round_clamp (32-bit signed in, BW out), instantiated three times in S2.

Verification
REQ-034 SHALL verify reset: assert rstn=0 mid-stream -> all outputs 0 immediately; after release, ready_in=1.
REQ-035 SHALL verify white pair: sof, (255,255,255) x2 with eol -> {Y=255, Cb=128, c_is_cr=0}, then {Y=255, Cr=128, c_is_cr=1}, first at 3 cycles.
REQ-036 SHALL verify clamp: (255,0,0) then (0,0,0) -> {Y=76, Cb=85}, then {Y=0, Cr=255} (raw 256 clamped).
REQ-037 SHALL verify backpressure: ready_out=0 for 4 cycles mid-stream of 8 pixels -> ready_in=0 those cycles; 8 outputs in order, none dropped or repeated.
REQ-038 SHALL verify odd line: 3 pixels, eol on 3rd, then a new line -> c_is_cr 0,1,0 then 0; eol_out on 3rd sample.
REQ-039 SHALL verify sof mid-line: sof on an ODD-phase pixel -> that pixel emits Cb with c_is_cr=0.
